// File: rtl/sigmoid_pkg.sv
// ---------------------------------------------------------------------------
// sigmoid_pkg
//   Definitions shared by the sigmoid evaluator and the neuron datapath:
//   default fixed-point geometry, the evaluator state encoding, and a
//   multiply/round/saturate helper for code that runs at the default widths.
//   No ports (package).
// ---------------------------------------------------------------------------
package sigmoid_pkg;

  localparam int PKG_DATA_W = 16;
  localparam int PKG_FRAC_W = 8;

  // 1.0 and 0.5 in the default Q8.8 format.
  localparam logic signed [PKG_DATA_W-1:0] ONE  = 16'sh0100;
  localparam logic signed [PKG_DATA_W-1:0] HALF = 16'sh0080;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEG  = 3'd1,
    ST_MAC  = 3'd2,
    ST_SYM  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Full-width product, round half up, then arithmetic shift back to Q8.8
  // and clip to the representable range.
  function automatic logic signed [PKG_DATA_W-1:0] rnd_sat(
    input logic signed [PKG_DATA_W-1:0] a,
    input logic signed [PKG_DATA_W-1:0] b
  );
    logic signed [2*PKG_DATA_W-1:0] p;
    p = a * b;
    p = p + 32'sd128;
    p = p >>> PKG_FRAC_W;
    if (p > 32'sd32767) begin
      rnd_sat = 16'sh7FFF;
    end else if (p < -32'sd32768) begin
      rnd_sat = 16'sh8000;
    end else begin
      rnd_sat = p[PKG_DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fxp_mul_rnd_sat.sv
// ---------------------------------------------------------------------------
// fxp_mul_rnd_sat
//   Combinational signed fixed-point multiply: full 2*DATA_W product, add
//   half an LSB of the result, arithmetic shift right by FRAC_W, saturate
//   to DATA_W bits.
//   Ports:
//     a_i  in  DATA_W  signed operand
//     b_i  in  DATA_W  signed operand
//     p_o  out DATA_W  rounded, saturated product
// ---------------------------------------------------------------------------
module fxp_mul_rnd_sat #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] RND_K = PW'(1) << (FRAC_W - 1);
  localparam logic signed [PW-1:0] MAX_V = (PW'(1) << (DATA_W - 1)) - PW'(1);
  // Bitwise complement of 2^(W-1)-1 is -2^(W-1).
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;

  always_comb begin
    prod = a_i * b_i;
    // The rounding add cannot overflow: |prod| <= 2^(PW-2).
    shr  = (prod + RND_K) >>> FRAC_W;
    if (shr > MAX_V) begin
      p_o = MAX_V[DATA_W-1:0];
    end else if (shr < MIN_V) begin
      p_o = MIN_V[DATA_W-1:0];
    end else begin
      p_o = shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/sigmoid_poly_eval.sv
// ---------------------------------------------------------------------------
// sigmoid_poly_eval
//   Iterative fixed-point sigmoid. |x| selects a segment (its integer part),
//   a per-segment polynomial in |x| is evaluated in Horner form one term per
//   cycle, out-of-range inputs saturate, and negative inputs use
//   sigmoid(-x) = 1 - sigmoid(x). Coefficients are loaded at run time.
//   Ports:
//     clk        in   1       rising-edge clock
//     rst_n      in   1       asynchronous reset, active low
//     in_valid   in   1       x presented
//     in_ready   out  1       high only while idle
//     in_x       in   DATA_W  signed x, Q(DATA_W-FRAC_W).FRAC_W
//     out_valid  out  1       y valid, held until out_ready
//     out_ready  in   1       consumer takes y
//     out_y      out  DATA_W  y in [0, ONE]
//     cfg_we     in   1       coefficient write strobe
//     cfg_addr   in   CFG_AW  seg*TERMS + k, k = power of |x|
//     cfg_data   in   DATA_W  signed coefficient
//     cfg_err    out  1       one-cycle pulse: write dropped
// ---------------------------------------------------------------------------
module sigmoid_poly_eval
  import sigmoid_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int FRAC_W  = PKG_FRAC_W,
  parameter int NUM_SEG = 6,
  parameter int TERMS   = 3,
  parameter int SEG_AW  = 3,
  parameter int CFG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_err
);

  localparam int NCOEF = NUM_SEG * TERMS;
  localparam int KW    = (TERMS > 2) ? $clog2(TERMS) : 1;

  localparam logic signed [DATA_W-1:0] ONE_V    = DATA_W'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] MAX_V    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic        [DATA_W:0]   SAT_LIM  = (DATA_W+1)'(NUM_SEG) << FRAC_W;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] coef_q [NCOEF];
  logic signed [DATA_W-1:0] snap_d [TERMS];
  logic signed [DATA_W-1:0] snap_q [TERMS];

  logic                     neg_q, sat_q, cfg_err_q;
  logic        [DATA_W-1:0] u_q;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic        [KW-1:0]     k_q, k_d;

  // ---- input decode (evaluated on the raw input while idle) ----
  logic              x_neg, x_sat, accept, cfg_ok, cfg_wr;
  logic [DATA_W-1:0] x_abs;
  logic [SEG_AW-1:0] x_seg;

  always_comb begin
    x_neg = in_x[DATA_W-1];
    x_abs = x_neg ? (~in_x + 1'b1) : in_x;
    // The most-negative code has no positive counterpart, so flag it directly.
    x_sat = (in_x == MIN_V) || ({1'b0, x_abs} >= SAT_LIM);
    x_seg = x_sat ? '0 : x_abs[FRAC_W +: SEG_AW];
  end

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign cfg_ok = (state_q == ST_IDLE) && (int'(cfg_addr) < NCOEF);
  assign cfg_wr = cfg_we && cfg_ok;

  // ---- coefficient table ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (cfg_addr == CFG_AW'(i)) coef_q[i] <= cfg_data;
      end
    end
  end

  // The selected segment's coefficients are copied at the accept edge, so
  // a write landing on that same edge only affects later inputs.
  always_comb begin
    for (int t = 0; t < TERMS; t++) begin
      snap_d[t] = '0;
      for (int s = 0; s < NUM_SEG; s++) begin
        if (x_seg == SEG_AW'(s)) snap_d[t] = coef_q[s*TERMS + t];
      end
    end
  end

  // ---- Horner step: acc*u rounded, plus next coefficient, saturating ----
  logic signed [DATA_W-1:0] mul_p, mac_sat;
  logic        [DATA_W:0]   mac_sum;

  fxp_mul_rnd_sat #(
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_mul (
    .a_i(acc_q),
    .b_i($signed(u_q)),
    .p_o(mul_p)
  );

  always_comb begin
    mac_sum = {mul_p[DATA_W-1], mul_p} + {snap_q[k_q][DATA_W-1], snap_q[k_q]};
    if (mac_sum[DATA_W] != mac_sum[DATA_W-1]) begin
      mac_sat = mac_sum[DATA_W] ? MIN_V : MAX_V;
    end else begin
      mac_sat = mac_sum[DATA_W-1:0];
    end
  end

  // ---- FSM next state / datapath updates ----
  logic signed [DATA_W-1:0] y_pos;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    y_d     = y_q;
    y_pos   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_SEG;
      end
      ST_SEG: begin
        acc_d   = snap_q[TERMS-1];
        k_d     = KW'(TERMS - 2);
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = mac_sat;
        if (k_q == '0) begin
          state_d = ST_SYM;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      ST_SYM: begin
        if (sat_q) begin
          y_pos = ONE_V;
        end else if (acc_q[DATA_W-1]) begin
          y_pos = '0;
        end else if (acc_q > ONE_V) begin
          y_pos = ONE_V;
        end else begin
          y_pos = acc_q;
        end
        y_d     = neg_q ? (ONE_V - y_pos) : y_pos;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      neg_q     <= 1'b0;
      sat_q     <= 1'b0;
      u_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      y_q       <= '0;
      cfg_err_q <= 1'b0;
      for (int t = 0; t < TERMS; t++) snap_q[t] <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      y_q       <= y_d;
      cfg_err_q <= cfg_we && !cfg_ok;
      if (accept) begin
        neg_q <= x_neg;
        sat_q <= x_sat;
        u_q   <= x_abs;
        for (int t = 0; t < TERMS; t++) snap_q[t] <= snap_d[t];
      end
    end
  end

  // All handshake outputs come straight from registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_y     = y_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sigmoid_poly_eval.sv
module tb_sigmoid_poly_eval;

  localparam int NCOEF = 18;
  localparam int LAT   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_x = '0;
  logic        out_ready = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        in_ready, out_valid, cfg_err;
  logic [15:0] out_y;

  sigmoid_poly_eval dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tbl[NCOEF];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Sigmoid approximation straight from the arithmetic definition.
  function automatic int ref_y(input logic [15:0] x);
    int xs, u, seg, acc, y;
    bit neg, sat;
    longint p;
    xs  = int'($signed(x));
    neg = (xs < 0);
    u   = neg ? -xs : xs;
    sat = (xs == -32768) || (u >= 6 * 256);
    if (sat) return neg ? 0 : 256;
    seg = u / 256;
    acc = tbl[seg*3 + 2];
    for (int k = 1; k >= 0; k--) begin
      p   = longint'(acc) * longint'(u) + 128;
      p   = p >>> 8;
      acc = sat16(longint'(sat16(p)) + longint'(tbl[seg*3 + k]));
    end
    y = (acc < 0) ? 0 : (acc > 256) ? 256 : acc;
    return neg ? 256 - y : y;
  endfunction

  task automatic cfg_write(input int addr, input logic [15:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr[4:0];
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
    check("cfg_err", {31'd0, cfg_err}, {31'd0, addr >= NCOEF});
    if (addr < NCOEF) tbl[addr] = int'($signed(data));
    $display("cfg addr=%0d data=0x%04h err=%0b", addr, data, cfg_err);
    tick();
    check("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
  endtask

  // One transaction: optional write on the accept cycle (same_wr) or during
  // the MAC phase (mid_wr); out_ready is held low for 'hold' cycles.
  task automatic run_x(input logic [15:0] x, input int hold, input bit mid_wr,
                       input bit same_wr, input logic [4:0] waddr,
                       input logic [15:0] wdata, output logic [15:0] y_obs);
    int exp_y, lat, guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    exp_y    = ref_y(x);
    in_valid = 1'b1;
    in_x     = x;
    if (same_wr) begin
      cfg_we   = 1'b1;
      cfg_addr = waddr;
      cfg_data = wdata;
    end
    tick();
    in_valid = 1'b0;
    in_x     = 16'($urandom);
    cfg_we   = 1'b0;
    if (same_wr) begin
      tbl[waddr] = int'($signed(wdata));
      check("same_cycle_err", {31'd0, cfg_err}, 32'd0);
    end
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (mid_wr && lat == 2) begin
        cfg_we   = 1'b1;
        cfg_addr = waddr;
        cfg_data = wdata;
      end
      tick();
      lat++;
      if (mid_wr && lat == 3) begin
        cfg_we = 1'b0;
        check("busy_wr_err", {31'd0, cfg_err}, 32'd1);
      end
    end
    check("latency", lat, LAT);
    check("out_y", {16'd0, out_y}, exp_y);
    y_obs = out_y;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_y", {16'd0, out_y}, exp_y);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drop_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    $display("x=0x%04h y=0x%04h exp=0x%04h lat=%0d", x, y_obs, exp_y[15:0], lat);
  endtask

  logic [15:0] y;

  initial begin
    for (int i = 0; i < NCOEF; i++) tbl[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", {16'd0, out_y}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Empty table: polynomial is zero.
    run_x(16'h0080, 0, 0, 0, 5'd0, 16'h0, y);
    check("zero_pos", {16'd0, y}, 32'h0000);
    run_x(16'hFF80, 0, 0, 0, 5'd0, 16'h0, y);
    check("zero_neg", {16'd0, y}, 32'h0100);

    cfg_write(0, 16'h0080);
    cfg_write(1, 16'h0040);
    cfg_write(2, 16'h0000);

    run_x(16'h0080, 0, 0, 0, 5'd0, 16'h0, y);
    check("dir_pos", {16'd0, y}, 32'h00A0);
    run_x(16'hFF80, 0, 0, 0, 5'd0, 16'h0, y);
    check("dir_sym", {16'd0, y}, 32'h0060);
    run_x(16'h0600, 0, 0, 0, 5'd0, 16'h0, y);
    check("sat_pos", {16'd0, y}, 32'h0100);
    run_x(16'hFA00, 0, 0, 0, 5'd0, 16'h0, y);
    check("sat_neg", {16'd0, y}, 32'h0000);
    run_x(16'h8000, 0, 0, 0, 5'd0, 16'h0, y);
    check("sat_min", {16'd0, y}, 32'h0000);

    // Backpressure.
    run_x(16'h0080, 10, 0, 0, 5'd0, 16'h0, y);

    // Write while busy is dropped.
    run_x(16'h0080, 0, 1, 0, 5'd0, 16'h7FFF, y);
    run_x(16'h0080, 0, 0, 0, 5'd0, 16'h0, y);
    check("busy_wr_dropped", {16'd0, y}, 32'h00A0);

    cfg_write(18, 16'h1234);

    // Write on the accept cycle is not seen by that input, only later ones.
    run_x(16'h0080, 0, 0, 1, 5'd0, 16'h0100, y);
    check("same_cycle_old", {16'd0, y}, 32'h00A0);
    run_x(16'h0080, 0, 0, 0, 5'd0, 16'h0, y);
    check("same_cycle_new", {16'd0, y}, 32'h0100);

    // Randomized table and inputs.
    for (int i = 0; i < NCOEF; i++) begin
      if ($urandom_range(0, 1) == 0) cfg_write(i, 16'($urandom));
      else cfg_write(i, 16'($urandom_range(0, 16'h0400) - 16'h0200));
    end
    for (int n = 0; n < 40; n++) begin
      logic [15:0] xr;
      if ($urandom_range(0, 3) == 0) xr = 16'($urandom);
      else xr = 16'($urandom_range(0, 16'h0E00) - 16'h0700);
      run_x(xr, int'($urandom_range(0, 2)), 0, 0, 5'd0, 16'h0, y);
    end

    // Reset while in MAC.
    in_valid = 1'b1;
    in_x     = 16'h0080;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_y", {16'd0, out_y}, 32'd0);
    check("mid_rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NCOEF; i++) tbl[i] = 0;
    tick();
    for (int s = 0; s < 6; s++) begin
      logic [15:0] xp;
      xp = 16'(s * 256 + 16'h0040);
      run_x(xp, 0, 0, 0, 5'd0, 16'h0, y);
      check("post_rst_pos", {16'd0, y}, 32'h0000);
      run_x(-xp, 0, 0, 0, 5'd0, 16'h0, y);
      check("post_rst_neg", {16'd0, y}, 32'h0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
